// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: widths, FSM state encoding, opcodes, ALU codes
// and the T3 strobe bundle produced by the opcode decoder.
package cpu_pkg;

  localparam int unsigned IR_W     = 32;
  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned ALU_W    = 5;
  localparam int unsigned COUNT_W  = 16;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_T0    = 3'd1,
    ST_T1    = 3'd2,
    ST_T2    = 3'd3,
    ST_T3    = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OPCODE_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPCODE_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPCODE_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  // ALU select for the PC+1 computation in T0
  localparam logic [ALU_W-1:0] ALU_PC_INC = 5'd19;

  typedef struct packed {
    logic gra;
    logic rin;
    logic rout;
    logic hi_out;
    logic lo_out;
    logic in_port_read;
    logic out_port_write;
  } t3_strobes_t;

endpackage

// File: rtl/control_decode.sv
// Combinational T3 decode: maps an opcode to its execute-phase strobes and flags
// opcodes outside the supported I/O subset.
module control_decode
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output t3_strobes_t         strobes_c,
  output logic                illegal_c
);

  always_comb begin
    strobes_c = '0;
    illegal_c = 1'b0;
    case (opcode)
      OP_IN: begin
        strobes_c.gra          = 1'b1;
        strobes_c.rin          = 1'b1;
        strobes_c.in_port_read = 1'b1;
      end
      OP_OUT: begin
        strobes_c.gra            = 1'b1;
        strobes_c.rout           = 1'b1;
        strobes_c.out_port_write = 1'b1;
      end
      OP_MFHI: begin
        strobes_c.gra    = 1'b1;
        strobes_c.rin    = 1'b1;
        strobes_c.hi_out = 1'b1;
      end
      OP_MFLO: begin
        strobes_c.gra    = 1'b1;
        strobes_c.rin    = 1'b1;
        strobes_c.lo_out = 1'b1;
      end
      OP_NOP, OP_HALT: begin
        strobes_c = '0;
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/io_control_unit.sv
// Fetch/execute control sequencer for the I/O instruction subset: T0..T3 fetch and
// execute, HALT on halt opcode or a latched stop request, retired-instruction count.
module io_control_unit
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic [IR_W-1:0]     ir,
  input  logic                mem_ready,
  input  logic                stop,
  output logic                PCout,
  output logic                PCin,
  output logic                pc_increment,
  output logic                MARin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                read,
  output logic                memRead,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Gra,
  output logic                Rin,
  output logic                Rout,
  output logic                HIout,
  output logic                LOout,
  output logic                InPort_read,
  output logic                OutPort_write,
  output logic [ALU_W-1:0]    alu_control,
  output logic                run,
  output logic                illegal_op,
  output logic [COUNT_W-1:0]  instr_count
);

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic                  stop_q;
  logic                  pcin_arm;
  logic                  in_t3_d;
  t3_strobes_t           dec;
  logic                  dec_illegal;
  logic                  unused_ir;

  assign unused_ir = ^ir[IR_W-OPCODE_W-1:0];

  // Opcode register only changes on the T2->T3 edge, so in T3 opcode_d equals opcode_q
  control_decode u_decode (
    .opcode    (opcode_d),
    .strobes_c (dec),
    .illegal_c (dec_illegal)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    if (mem_ready) state_d = ST_T2;
      ST_T2: begin
        state_d  = ST_T3;
        opcode_d = ir[IR_W-1:IR_W-OPCODE_W];
      end
      ST_T3:    state_d = ((opcode_q == OP_HALT) || stop_q || stop) ? ST_HALT : ST_T0;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  assign in_t3_d = (state_d == ST_T3);

  // Strobes are registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q       <= ST_RESET;
      opcode_q      <= '0;
      stop_q        <= 1'b0;
      pcin_arm      <= 1'b0;
      PCout         <= 1'b0;
      pc_increment  <= 1'b0;
      MARin         <= 1'b0;
      Zin           <= 1'b0;
      Zlowout       <= 1'b0;
      read          <= 1'b0;
      memRead       <= 1'b0;
      MDRin         <= 1'b0;
      MDRout        <= 1'b0;
      IRin          <= 1'b0;
      Gra           <= 1'b0;
      Rin           <= 1'b0;
      Rout          <= 1'b0;
      HIout         <= 1'b0;
      LOout         <= 1'b0;
      InPort_read   <= 1'b0;
      OutPort_write <= 1'b0;
      alu_control   <= '0;
      run           <= 1'b0;
      illegal_op    <= 1'b0;
      instr_count   <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      stop_q   <= (state_q == ST_T3) ? 1'b0
                : (stop_q | (stop & (state_q inside {ST_T0, ST_T1, ST_T2})));
      if (state_q == ST_T3) begin
        instr_count <= instr_count + COUNT_W'(1);
        if (dec_illegal) illegal_op <= 1'b1;
      end
      run           <= state_d inside {ST_T0, ST_T1, ST_T2, ST_T3};
      PCout         <= (state_d == ST_T0);
      MARin         <= (state_d == ST_T0);
      pc_increment  <= (state_d == ST_T0);
      Zin           <= (state_d == ST_T0);
      alu_control   <= (state_d == ST_T0) ? ALU_PC_INC : '0;
      read          <= (state_d == ST_T1);
      memRead       <= (state_d == ST_T1);
      MDRin         <= (state_d == ST_T1);
      Zlowout       <= (state_d == ST_T1);
      pcin_arm      <= (state_d == ST_T1);
      MDRout        <= (state_d == ST_T2);
      IRin          <= (state_d == ST_T2);
      Gra           <= in_t3_d & dec.gra;
      Rin           <= in_t3_d & dec.rin;
      Rout          <= in_t3_d & dec.rout;
      HIout         <= in_t3_d & dec.hi_out;
      LOout         <= in_t3_d & dec.lo_out;
      InPort_read   <= in_t3_d & dec.in_port_read;
      OutPort_write <= in_t3_d & dec.out_port_write;
    end
  end

  // PC loads only in the T1 cycle where read data is valid, so it advances once per fetch
  assign PCin = pcin_arm & mem_ready;

endmodule

// File: tb/tb_io_control_unit.sv
// Self-checking bench for io_control_unit: directed vector table, hand-written
// reset/wrap sequences and a randomized instruction stream against a trace model.
module tb_io_control_unit;

  logic        clk = 1'b0;
  logic        clr, mem_ready, stop;
  logic [31:0] ir;
  logic        PCout, PCin, pc_increment, MARin, Zin, Zlowout, read, memRead, MDRin;
  logic        MDRout, IRin, Gra, Rin, Rout, HIout, LOout, InPort_read, OutPort_write;
  logic [4:0]  alu_control;
  logic        run, illegal_op;
  logic [15:0] instr_count;

  io_control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .PCin(PCin), .pc_increment(pc_increment), .MARin(MARin), .Zin(Zin),
    .Zlowout(Zlowout), .read(read), .memRead(memRead), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Gra(Gra), .Rin(Rin), .Rout(Rout), .HIout(HIout), .LOout(LOout),
    .InPort_read(InPort_read), .OutPort_write(OutPort_write), .alu_control(alu_control),
    .run(run), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_out, pc_in, pc_inc, mar_in, z_in, zlow_out, rd, mem_read, mdr_in;
    logic mdr_out, ir_in, gra, rin, rout, hi_out, lo_out, in_rd, out_wr;
    logic [4:0] alu;
    logic run;
  } obs_t;

  typedef struct {
    logic [31:0] irv;
    int          waits;
    int          stop_at;
    int          exp_count;
    bit          exp_ill;
    bit          exp_halt;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int m_count;
  bit m_ill;
  bit m_halted;

  function automatic obs_t observe();
    obs_t o;
    o = {PCout, PCin, pc_increment, MARin, Zin, Zlowout, read, memRead, MDRin,
         MDRout, IRin, Gra, Rin, Rout, HIout, LOout, InPort_read, OutPort_write,
         alu_control, run};
    return o;
  endfunction

  function automatic bit is_legal(logic [4:0] op);
    return (op >= 5'b10110) && (op <= 5'b11011);
  endfunction

  // Phase: 0 idle (RESET/HALT), 1 T0, 2 T1, 3 T2, 4 T3
  function automatic obs_t expect_out(int ph, logic [4:0] op, bit mr);
    obs_t e;
    e = '0;
    case (ph)
      1: begin e.pc_out = 1; e.mar_in = 1; e.pc_inc = 1; e.z_in = 1; e.alu = 5'd19; e.run = 1; end
      2: begin e.rd = 1; e.mem_read = 1; e.mdr_in = 1; e.zlow_out = 1; e.pc_in = mr; e.run = 1; end
      3: begin e.mdr_out = 1; e.ir_in = 1; e.run = 1; end
      4: begin
        e.run = 1;
        case (op)
          5'b10110: begin e.gra = 1; e.rin = 1; e.in_rd = 1; end
          5'b10111: begin e.gra = 1; e.rout = 1; e.out_wr = 1; end
          5'b11000: begin e.gra = 1; e.rin = 1; e.hi_out = 1; end
          5'b11001: begin e.gra = 1; e.rin = 1; e.lo_out = 1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = observe();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: strobes got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: entered #1 after a rising edge, leaves #1 after the next one
  task automatic cyc(input bit c, input bit mr, input bit st, input logic [31:0] irv,
                     input int ph, input logic [4:0] op, input string name, input bit chk);
    clr = c; mem_ready = mr; stop = st; ir = irv;
    #1;
    if (chk) check_obs(name, expect_out(ph, op, mr));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, 1'b1, $urandom, 0, 5'd0, "reset_hold", 1'b0);
    cyc(1'b0, 1'b0, 1'b0, $urandom, 0, 5'd0, "reset_hold", 1'b0);
    check_val("reset_count", int'(instr_count), 0);
    check_val("reset_illegal", int'(illegal_op), 0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 0, 5'd0, "reset_state", 1'b1);
    m_count = 0; m_ill = 0; m_halted = 0;
  endtask

  task automatic run_instr(input logic [4:0] op, input int waits, input int stop_at,
                           input logic [31:0] irv, input bit scramble, input bit chk);
    int   total;
    bit   stopped;
    int   ph;
    bit   mr;
    logic [31:0] v;
    total   = waits + 4;
    stopped = 0;
    for (int k = 0; k < total; k++) begin
      if (k == 0) ph = 1;
      else if (k <= waits + 1) ph = 2;
      else if (k == waits + 2) ph = 3;
      else ph = 4;
      if (ph == 2) mr = (k == waits + 1);
      else mr = scramble ? 1'($urandom_range(0, 1)) : 1'b1;
      v = (scramble && ph != 3) ? 32'($urandom) : irv;
      if (k == stop_at) stopped = 1;
      if (ph == 4 && chk) begin
        check_val("count_in_t3", int'(instr_count), m_count);
        check_val("illegal_in_t3", int'(illegal_op), int'(m_ill));
      end
      cyc(1'b1, mr, k == stop_at, v, ph, op, "instr_cycle", chk);
    end
    m_count = (m_count + 1) % 65536;
    if (!is_legal(op)) m_ill = 1;
    if (op == 5'b11011 || stopped) m_halted = 1;
    if (chk) begin
      check_val("count_after", int'(instr_count), m_count);
      check_val("illegal_after", int'(illegal_op), int'(m_ill));
      check_val("run_after", int'(run), int'(!m_halted));
    end
  endtask

  task automatic idle_cycles(input int n, input string name);
    for (int k = 0; k < n; k++)
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 0, 5'd0, name, 1'b1);
    check_val("idle_count", int'(instr_count), m_count);
    check_val("idle_illegal", int'(illegal_op), int'(m_ill));
  endtask

  vec_t tbl [7];

  initial begin
    logic [4:0] op;
    int w, sa, r;

    tbl[0] = '{32'hB8000000, 0, -1, 1, 1'b0, 1'b0};
    tbl[1] = '{{5'b10110, 27'h0000123}, 3, -1, 2, 1'b0, 1'b0};
    tbl[2] = '{{5'b11000, 27'h7ABCDEF}, 1, -1, 3, 1'b0, 1'b0};
    tbl[3] = '{{5'b11001, 27'h0000001}, 0, -1, 4, 1'b0, 1'b0};
    tbl[4] = '{{5'b11111, 27'h5555555}, 2, -1, 5, 1'b1, 1'b0};
    tbl[5] = '{{5'b00000, 27'h0000000}, 0, -1, 6, 1'b1, 1'b0};
    tbl[6] = '{{5'b11010, 27'h2222222}, 2, 1, 7, 1'b1, 1'b1};

    clr = 1'b0; mem_ready = 1'b0; stop = 1'b0; ir = 32'h0;
    m_count = 0; m_ill = 0; m_halted = 0;
    @(posedge clk);
    #1;

    // Directed vector table, run back to back from one reset
    do_reset();
    for (int i = 0; i < 7; i++) begin
      logic [31:0] iv;
      iv = tbl[i].irv;
      run_instr(iv[31:27], tbl[i].waits, tbl[i].stop_at, iv, 1'b0, 1'b1);
      check_val("tbl_count", int'(instr_count), tbl[i].exp_count);
      check_val("tbl_illegal", int'(illegal_op), int'(tbl[i].exp_ill));
      check_val("tbl_run", int'(run), int'(!tbl[i].exp_halt));
    end
    idle_cycles(6, "halt_idle");

    // Halt opcode after a fresh reset clears the sticky illegal flag
    do_reset();
    run_instr(5'b11011, 1, -1, {5'b11011, 27'h0}, 1'b0, 1'b1);
    check_val("halt_op_run", int'(run), 0);
    idle_cycles(4, "halt_op_idle");

    // Reset asserted during T2 abandons the instruction
    do_reset();
    run_instr(5'b11111, 0, -1, {5'b11111, 27'h0}, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 32'hB8000000, 1, 5'b10111, "abort_t0", 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 32'hB8000000, 2, 5'b10111, "abort_t1", 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'hB8000000, 3, 5'b10111, "abort_t2", 1'b1);
    m_count = 0; m_ill = 0; m_halted = 0;
    check_val("abort_count", int'(instr_count), 0);
    check_val("abort_illegal", int'(illegal_op), 0);
    cyc(1'b1, 1'b1, 1'b0, 32'hB8000000, 0, 5'd0, "abort_reset_state", 1'b1);
    run_instr(5'b10111, 0, -1, 32'hB8000000, 1'b0, 1'b1);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r < 15) op = 5'(5'b10110 + $urandom_range(0, 4));
      else if (r == 15) op = 5'b11011;
      else op = 5'($urandom);
      w  = $urandom_range(0, 4);
      sa = ($urandom_range(0, 14) == 0) ? $urandom_range(0, w + 3) : -1;
      run_instr(op, w, sa, {op, 27'($urandom)}, 1'b1, 1'b1);
      if (m_halted) begin
        idle_cycles(3, "rand_halt_idle");
        do_reset();
      end
    end

    // Counter wrap over 65536 nops
    do_reset();
    for (int i = 0; i < 65536; i++)
      run_instr(5'b11010, 0, -1, {5'b11010, 27'h0}, 1'b0, i >= 65534);
    check_val("wrap_count", int'(instr_count), 0);
    check_val("wrap_illegal", int'(illegal_op), 0);
    check_val("wrap_run", int'(run), 1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1, 5'd0, "wrap_next_t0", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
